// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer front end of the sequence detectors.
//   ser_state_t        : shifter state (empty / shifting a word out)
//   SER_WIDTH_DEFAULT  : default word width in bits
package serdes_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage : serdes_pkg

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of bit_serializer.
//   in_data, in_valid  : word offered by the producer
//   in_ready           : serializer can take a word this cycle
//   out_bit            : serial bit stream (feeds a detector's inp_bit)
//   out_valid          : out_bit carries word data rather than idle fill
//   out_last           : out_bit is the final bit of a word
//   busy               : shifter or holding register occupied
// master = word producer / bit consumer side, slave = the serializer.
interface bit_serializer_if
    import serdes_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_bit,
        input  out_valid,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_bit,
        output out_valid,
        output out_last,
        output busy
    );

endinterface : bit_serializer_if

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes WIDTH-bit words over valid/ready and
// emits one bit per clock. A one-word holding register lets the next word be
// taken while the current one shifts out, giving a gapless stream when the
// producer keeps up. With nothing to send, out_bit carries IDLE_BIT.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : synchronous, active-high; discards any word in flight or held
//   ser    : bit_serializer_if.slave (in_data/in_valid/in_ready,
//            out_bit/out_valid/out_last/busy)
// Parameters: WIDTH (2..32), LSB_FIRST (0 = MSB first), IDLE_BIT.
module bit_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    bit_serializer_if.slave   ser
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       state_reg,     state_next;
    logic [WIDTH-1:0] shift_reg,     shift_next;
    logic [WIDTH-1:0] hold_reg,      hold_next;
    logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic             hold_full_reg, hold_full_next;

    logic [WIDTH-1:0] shifted;
    logic             ready;
    logic             accept;
    logic             at_last;

    // The hold register is the only buffer beyond the shifter, so a word can
    // be taken whenever it is empty (the shifter either takes it directly or
    // the hold register does).
    assign ready   = !hold_full_reg && !reset;
    assign accept  = ser.in_valid && ready;
    assign at_last = (bit_cnt_reg == LAST_CNT);

    assign ser.in_ready = ready;

    // One-position shift toward the output end, zero filled at the far end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (LSB_FIRST) begin : g_right
            if (gi == WIDTH - 1) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_take
                assign shifted[gi] = shift_reg[gi+1];
            end
        end else begin : g_left
            if (gi == 0) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_take
                assign shifted[gi] = shift_reg[gi-1];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            shift_reg     <= '0;
            hold_reg      <= '0;
            bit_cnt_reg   <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            bit_cnt_reg   <= bit_cnt_next;
            hold_full_reg <= hold_full_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        bit_cnt_next   = bit_cnt_reg;
        hold_full_next = hold_full_reg;

        unique case (state_reg)
            S_IDLE: begin
                // accept implies an empty hold register, so load directly
                if (accept) begin
                    shift_next   = ser.in_data;
                    bit_cnt_next = '0;
                    state_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!at_last) begin
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    if (accept) begin
                        hold_next      = ser.in_data;
                        hold_full_next = 1'b1;
                    end
                end else if (hold_full_reg) begin
                    // accept cannot coincide here: ready is low while held
                    shift_next     = hold_reg;
                    hold_full_next = 1'b0;
                    bit_cnt_next   = '0;
                end else if (accept) begin
                    // last bit leaving and a fresh word arriving: no gap
                    shift_next   = ser.in_data;
                    bit_cnt_next = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs, decoded from registers only
    always_comb begin
        ser.out_valid = (state_reg == S_SHIFT);
        ser.out_last  = ser.out_valid && at_last;
        ser.busy      = ser.out_valid || hold_full_reg;
        if (ser.out_valid) begin
            ser.out_bit = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
        end else begin
            ser.out_bit = IDLE_BIT;
        end
    end

endmodule : bit_serializer

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer. Four instances cover WIDTH=8
// MSB-first, WIDTH=8 LSB-first, WIDTH=2 with IDLE_BIT=1 and WIDTH=32
// LSB-first. A reference model keeps, per instance, a queue of the bits still
// to be emitted (each tagged with whether it ends its word); the queue length
// alone decides readiness, validity and busy. Directed scenarios run first,
// then randomized streams with occasional resets.
module tb_bit_serializer;

    localparam int N_DUT = 4;

    function automatic int w_of(input int i);
        case (i)
            0:       return 8;
            1:       return 8;
            2:       return 2;
            default: return 32;
        endcase
    endfunction

    function automatic bit lsb_of(input int i);
        return (i == 1) || (i == 3);
    endfunction

    function automatic bit idle_of(input int i);
        return (i == 2);
    endfunction

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]      drv_data [N_DUT];
    logic [N_DUT-1:0] drv_valid;
    logic [N_DUT-1:0] drv_rst;
    logic [N_DUT-1:0] obs_ready, obs_bit, obs_valid, obs_last, obs_busy;

    int n_checks = 0;
    int n_fails  = 0;

    exp_t exp_q [N_DUT][$];
    int   model_acc [N_DUT];
    int   done_cnt  [N_DUT];
    int   dut_acc   [N_DUT];
    int   last_cnt  [N_DUT];

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int GW = w_of(gi);
        localparam bit GL = lsb_of(gi);
        localparam bit GI = idle_of(gi);

        bit_serializer_if #(.WIDTH(GW)) ser ();

        assign ser.in_data    = drv_data[gi][GW-1:0];
        assign ser.in_valid   = drv_valid[gi];
        assign obs_ready[gi]  = ser.in_ready;
        assign obs_bit[gi]    = ser.out_bit;
        assign obs_valid[gi]  = ser.out_valid;
        assign obs_last[gi]   = ser.out_last;
        assign obs_busy[gi]   = ser.busy;

        bit_serializer #(
            .WIDTH     (GW),
            .LSB_FIRST (GL),
            .IDLE_BIT  (GI)
        ) dut (
            .clk   (clk),
            .reset (drv_rst[gi]),
            .ser   (ser)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: advance one clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            int w;
            bit rdy;
            w = w_of(i);
            if (drv_rst[i]) begin
                // a last bit on display during the reset cycle was still emitted
                if (exp_q[i].size() > 0 && exp_q[i][0].last) done_cnt[i]++;
                exp_q[i].delete();
            end else begin
                rdy = (exp_q[i].size() <= w);
                if (exp_q[i].size() > 0) begin
                    if (exp_q[i][0].last) done_cnt[i]++;
                    void'(exp_q[i].pop_front());
                end
                if (drv_valid[i] && rdy) begin
                    model_acc[i]++;
                    for (int b = 0; b < w; b++) begin
                        int   idx;
                        exp_t e;
                        idx    = lsb_of(i) ? b : (w - 1 - b);
                        e.b    = drv_data[i][idx];
                        e.last = (b == w - 1);
                        exp_q[i].push_back(e);
                    end
                end
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            logic has;
            has = (exp_q[i].size() > 0);
            check_eq($sformatf("ready%0d", i), obs_ready[i],
                     !drv_rst[i] && (exp_q[i].size() <= w_of(i)));
            check_eq($sformatf("valid%0d", i), obs_valid[i], has);
            check_eq($sformatf("bit%0d", i), obs_bit[i],
                     has ? exp_q[i][0].b : idle_of(i));
            check_eq($sformatf("last%0d", i), obs_last[i], has && exp_q[i][0].last);
            check_eq($sformatf("busy%0d", i), obs_busy[i], has);
            if (obs_last[i]) last_cnt[i]++;
            if (drv_valid[i] && obs_ready[i] && !drv_rst[i]) dut_acc[i]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, vmask, rmask, bmask;
        int lpos;

        for (int i = 0; i < N_DUT; i++) begin
            drv_data[i]  = '0;
            model_acc[i] = 0;
            done_cnt[i]  = 0;
            dut_acc[i]   = 0;
            last_cnt[i]  = 0;
        end
        drv_valid = '0;
        drv_rst   = '1;
        repeat (3) tick();
        drv_rst = '0;

        // Single word 0xB0, MSB first
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'hB0;
        tick();
        drv_valid[0] = 1'b0;
        got  = '0;
        lpos = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = {got[30:0], obs_bit[0]};
            if (obs_last[0]) lpos = k;
            tick();
        end
        check_eq("single_bits", got, 32'hB0);
        check_eq("single_lastpos", lpos, 7);
        @(negedge clk);
        check_eq("single_after", {obs_valid[0], obs_bit[0]}, 2'b00);
        tick();
        $display("single word 0xB0: bits %0h last at %0d", got, lpos);

        // Back-to-back 0x0B then 0xB0
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'h0B;
        tick();
        drv_data[0] = 32'hB0;
        got = '0; vmask = '0; rmask = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            got   = {got[30:0],   obs_bit[0]};
            vmask = {vmask[30:0], obs_valid[0]};
            rmask = {rmask[30:0], obs_ready[0]};
            tick();
            if (k == 0) drv_valid[0] = 1'b0;
        end
        check_eq("b2b_bits", got, 32'h0BB0);
        check_eq("b2b_valid", vmask, 32'hFFFF);
        check_eq("b2b_ready", rmask, 32'h80FF);
        $display("back-to-back 0x0B,0xB0: bits %0h ready %0h", got, rmask);

        // Stall of three cycles between 0xFF and 0x00
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'hFF;
        tick();
        drv_valid[0] = 1'b0;
        got = '0; vmask = '0; bmask = '0;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            got   = {got[30:0],   obs_bit[0]};
            vmask = {vmask[30:0], obs_valid[0]};
            bmask = {bmask[30:0], obs_busy[0]};
            tick();
            if (k == 9) begin
                drv_valid[0] = 1'b1;
                drv_data[0]  = 32'h00;
            end
            if (k == 10) drv_valid[0] = 1'b0;
        end
        check_eq("stall_bits", got, 32'h7F800);
        check_eq("stall_valid", vmask, 32'h7F8FF);
        check_eq("stall_busy", bmask, 32'h7F8FF);
        $display("stall 0xFF,gap,0x00: valid %0h busy %0h", vmask, bmask);

        // Reset on bit 4 of 0xA5 while 0x3C is held
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'hA5;
        tick();
        drv_data[0] = 32'h3C;
        tick();
        drv_valid[0] = 1'b0;
        tick();
        tick();
        drv_rst[0] = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rst_outputs", {obs_valid[0], obs_busy[0], obs_ready[0]}, 3'b000);
        tick();
        drv_rst[0]   = 1'b0;
        drv_valid[0] = 1'b1;
        drv_data[0]  = 32'hC3;
        tick();
        drv_valid[0] = 1'b0;
        got = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = {got[30:0], obs_bit[0]};
            tick();
        end
        check_eq("rst_next_word", got, 32'hC3);
        $display("reset mid-word: next word bits %0h", got);

        // LSB first, 0x0D -> 1,0,1,1,0,0,0,0
        drv_valid[1] = 1'b1;
        drv_data[1]  = 32'h0D;
        tick();
        drv_valid[1] = 1'b0;
        got  = '0;
        lpos = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = {got[30:0], obs_bit[1]};
            if (obs_last[1]) lpos = k;
            tick();
        end
        check_eq("lsb_bits", got, 32'hB0);
        check_eq("lsb_lastpos", lpos, 7);
        $display("lsb-first 0x0D: bits %0h last at %0d", got, lpos);

        // Randomized streams on all instances
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int mode;
            mode = (cyc / 500) % 3;
            for (int i = 0; i < N_DUT; i++) begin
                int w;
                w = w_of(i);
                case (mode)
                    0:       drv_valid[i] = 1'b1;
                    1:       drv_valid[i] = ($urandom_range(0, 3) != 0);
                    default: drv_valid[i] = ($urandom_range(0, 9) < 3);
                endcase
                drv_data[i] = (w == 32) ? $urandom : ($urandom & ((32'd1 << w) - 32'd1));
                drv_rst[i]  = ($urandom_range(0, 299) == 0);
            end
            tick();
        end
        drv_valid = '0;
        drv_rst   = '0;
        repeat (100) tick();

        for (int i = 0; i < N_DUT; i++) begin
            check_eq($sformatf("accepts%0d", i), dut_acc[i], model_acc[i]);
            check_eq($sformatf("words%0d", i), last_cnt[i], done_cnt[i]);
            check_eq($sformatf("drained%0d", i), obs_busy[i], 1'b0);
            $display("instance %0d: width %0d accepted %0d words, %0d out_last pulses",
                     i, w_of(i), dut_acc[i], last_cnt[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_bit_serializer

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `out_bit`, which connects directly to a detector's `inp_bit`. A one-word holding register lets the next word be accepted while the current word shifts out, so back-to-back words produce a gapless bit stream. When no data is pending, the block drives a fixed idle bit.

## Interface
- `WIDTH`, default 8: word width in bits. Legal range is 2..32.
- `LSB_FIRST`, default 0: 0 sends the MSB first; 1 sends the LSB first.
- `IDLE_BIT`, default 0: value driven on `out_bit` when `out_valid` is 0.

Ports:
- `clk`  in  1  sole clock; everything is clocked on the posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block can accept a word this cycle.
- `out_bit`  out  1  serial bit; feeds the detector's `inp_bit`.
- `out_valid`  out  1  `out_bit` carries word data, not the idle fill.
- `out_last`  out  1  `out_bit` is the final bit of a word.
- `busy`  out  1  the shifter or the holding register is occupied.

## Operation
**State machine**
- Two states: `S_IDLE` (shifter empty) and `S_SHIFT`.
- Registers: `shift_reg[WIDTH]`, `bit_cnt` of width `$clog2(WIDTH)`, `hold_reg[WIDTH]`, `hold_full`.

**Handshake**
- `in_ready = !hold_full && !reset`.
- A word is accepted on an edge where `in_valid && in_ready`.
- `in_data` is ignored when no accept occurs.

**Where an accepted word goes**
- The shifter is *free at this edge* when it is in `S_IDLE`, or when it is in `S_SHIFT` with `bit_cnt == WIDTH-1`.
- If the shifter is free at this edge and `hold_full == 0`, the word loads directly into `shift_reg`. Then `bit_cnt` is set to 0 and the state becomes `S_SHIFT`.
- Otherwise the word goes to `hold_reg` and `hold_full` is set to 1.

**Shifting, per edge in `S_SHIFT`**
- If `bit_cnt < WIDTH-1`: shift `shift_reg` (left for MSB-first, right for LSB-first) and increment `bit_cnt`.
- If `bit_cnt == WIDTH-1`, one of three things happens:
  - `hold_full` is 1: load `hold_reg` into `shift_reg`, clear `hold_full`, set `bit_cnt` to 0, stay in `S_SHIFT`.
  - An accept is occurring: the direct load above applies.
  - Otherwise: go to `S_IDLE`.

**Outputs** (combinational from flops only)
- `out_valid = (state == S_SHIFT)`.
- `out_bit` is `shift_reg[WIDTH-1]` (MSB-first) or `shift_reg[0]` (LSB-first) when `out_valid` is 1; otherwise it is `IDLE_BIT`.
- `out_last = out_valid && (bit_cnt == WIDTH-1)`.
- `busy = out_valid || hold_full`.

**Reset**
- Any cycle with `reset` high clears `state`, `bit_cnt`, `hold_full` and `shift_reg` at the edge.
- A word in flight or held is discarded, and no accept occurs.

**Outputs during and after reset**
- `in_ready` is 0 while `reset` is high and 1 on the first cycle after it.
- `out_valid`, `out_last` and `busy` are 0.
- `out_bit` is `IDLE_BIT`.

## Timing
- **Latency:** a word accepted at edge N into an empty block drives its first bit during the cycle after edge N. Its last bit appears WIDTH-1 cycles later, with `out_last` high.
- **Throughput:** one word per WIDTH cycles. With `in_valid` held high, `out_valid` never drops between words.
- **`in_ready` pattern under continuous streaming:**
  - `in_ready` is high on the first-bit cycle of each word; the next word is taken into hold there.
  - It then stays low until the edge where hold transfers into the shifter.
- **Simultaneous events:**
  - Hold transfer and a new accept cannot coincide, because `in_ready` is low whenever `hold_full` is 1.
  - A last-bit edge with an empty hold and a concurrent accept loads directly into the shifter with no gap.
- **Bit order:** a gap between words produces `IDLE_BIT` cycles. Downstream detectors see these as real input bits; this is intended.

## Structure
- Shared package `serdes_pkg`:
  - State enum `ser_state_t` { `S_IDLE`, `S_SHIFT` }.
  - Default `WIDTH` constant `SER_WIDTH_DEFAULT = 8`.
- Single module with no sub-module.
- The integration wrapper `ser_detect_top` is built separately: `bit_serializer` → `seq_detect_1011`, sharing `clk` and `reset`.

## Test plan
- **Single word, MSB-first:** after reset, `WIDTH=8`, accept 0xB0. `out_bit` = 1,0,1,1,0,0,0,0 on cycles 1–8, `out_last` high only on cycle 8, then `out_valid=0` and `out_bit=0`. Through the detector, `seq_seen` pulses exactly once, in the cycle after the 4th bit.
- **Back-to-back:** `in_valid` held high with 0x0B then 0xB0. 16 contiguous valid bits 0000_1011_1011_0000. `in_ready` is low in cycles 2–8. `out_valid` stays high for 16 cycles with no gap.
- **Stall:** `in_valid` drops for 3 cycles between 0xFF and 0x00. Three `IDLE_BIT` cycles with `out_valid=0` sit between the words, and `busy` is low during them.
- **Reset mid-word:** assert `reset` on bit 4 of 0xA5 while 0x3C is held. The next cycle has `out_valid=0`, `busy=0`, `in_ready=0`. After release, 0xC3 serializes cleanly with no residue from 0xA5 or 0x3C.
- **LSB-first:** `LSB_FIRST=1`, accept 0x0D. `out_bit` = 1,0,1,1,0,0,0,0.
- **Parameter sweep:** `WIDTH=2` and `WIDTH=32` with random streams. The scoreboard matches the serialized order, counts exactly one `out_last` per accepted word, and checks that no handshake is lost under random `in_valid`.
